// File: rtl/gate_array_pipe.sv
// Two-stage registered bitwise gate unit (AND/OR/XOR/NAND/NOR/XNOR/NOT a/pass a) with
// valid/ready flow control and a registered reduction output. Optional: GATE_ARRAY_PIPE_STATS_EN.
module gate_array_pipe #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned RED_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_red
`ifdef GATE_ARRAY_PIPE_STATS_EN
    ,
    input  logic             clr_cnt,
    output logic [15:0]      beat_cnt
`endif
);

    logic             s1_valid_q;
    logic [2:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic             s2_valid_q;
    logic [WIDTH-1:0] y_q;
    logic             y_red_q;
    logic [WIDTH-1:0] y_d;
    logic             y_red_d;
    logic             s1_ready;
    logic             s2_ready;

    assign s2_ready = !s2_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign in_ready = s1_ready;

    always_comb begin
        y_d = '0;
        case (s1_op_q)
            3'b000: y_d = s1_a_q & s1_b_q;
            3'b001: y_d = s1_a_q | s1_b_q;
            3'b010: y_d = s1_a_q ^ s1_b_q;
            3'b011: y_d = ~(s1_a_q & s1_b_q);
            3'b100: y_d = ~(s1_a_q | s1_b_q);
            3'b101: y_d = ~(s1_a_q ^ s1_b_q);
            3'b110: y_d = ~s1_a_q;
            3'b111: y_d = s1_a_q;
        endcase
    end

    // Reduction taken from the value being registered so y_red always matches y.
    always_comb begin
        y_red_d = &y_d;
        case (RED_MODE)
            1:       y_red_d = |y_d;
            2:       y_red_d = ^y_d;
            default: y_red_d = &y_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else if (s1_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_op_q <= op;
                s1_a_q  <= a;
                s1_b_q  <= b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            y_red_q    <= 1'b0;
        end else if (s2_ready) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                y_q     <= y_d;
                y_red_q <= y_red_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign y         = y_q;
    assign y_red     = y_red_q;

`ifdef GATE_ARRAY_PIPE_STATS_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Clear has priority over a coincident transfer; count saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt)
            cnt_d = '0;
        else if (s2_valid_q && out_ready && (cnt_q != '1))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign beat_cnt = cnt_q;
`endif

endmodule
